trng_word_packer: RTL and testbench

Upstream producer for the 64-bit TRNG FIFO. Accepts single raw bits from the ring-oscillator sampler and runs a repetition-count health test on them. Optionally applies von Neumann debiasing, then packs the bits into 64-bit words and writes each completed word into the FIFO using its wr_en/full handshake.

---
 rtl/trng_word_packer.sv | 175 +++++++++++++++++
 tb/tb_trng_word_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_word_packer.sv
// trng_word_packer: feeds 64-bit words from a ring-oscillator TRNG into a FIFO.
// Accepted raw bits pass through a repetition-count health test, are packed
// MSB-first into a 64-bit word, and each finished word is written into the
// FIFO through its wr_en/full handshake.
// Optional build macro TRNG_VN_DEBIAS_EN inserts a von Neumann corrector
// between the health test and the packer.
module trng_word_packer #(
    parameter int RCT_LIMIT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        raw_bit,
    input  logic        raw_valid,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [63:0] fifo_din,
    output logic [15:0] drop_count,
    output logic        health_fail
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PUSH    = 1'b1
    } state_t;

    localparam logic [7:0] RCT_LIM = 8'(RCT_LIMIT);

    state_t      state_r, state_s;
    logic [63:0] shift_r, shift_s;
    logic [6:0]  cnt_r, cnt_s;
    logic [7:0]  run_len_r, run_len_s;
    logic        prev_bit_r, prev_bit_s;
    logic [63:0] din_r, din_s;
    logic [15:0] drop_r, drop_s;
    logic        hf_r, hf_s;
    logic        accept_s;
    logic        pack_valid_s;
    logic        pack_bit_s;
`ifdef TRNG_VN_DEBIAS_EN
    logic        pair_valid_r, pair_valid_s;
    logic        pair_bit_r, pair_bit_s;
`endif

    // Register update with synchronous reset; any pending word is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= COLLECT;
            shift_r    <= 64'd0;
            cnt_r      <= 7'd0;
            run_len_r  <= 8'd0;
            prev_bit_r <= 1'b0;
            din_r      <= 64'd0;
            drop_r     <= 16'd0;
            hf_r       <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
            pair_valid_r <= 1'b0;
            pair_bit_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            cnt_r      <= cnt_s;
            run_len_r  <= run_len_s;
            prev_bit_r <= prev_bit_s;
            din_r      <= din_s;
            drop_r     <= drop_s;
            hf_r       <= hf_s;
`ifdef TRNG_VN_DEBIAS_EN
            pair_valid_r <= pair_valid_s;
            pair_bit_r   <= pair_bit_s;
`endif
        end
    end

    // Next-state: health test, optional debias, packing, push handshake, drops.
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        cnt_s        = cnt_r;
        run_len_s    = run_len_r;
        prev_bit_s   = prev_bit_r;
        din_s        = din_r;
        drop_s       = drop_r;
        hf_s         = hf_r;
        pack_valid_s = 1'b0;
        pack_bit_s   = 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
        pair_valid_s = pair_valid_r;
        pair_bit_s   = pair_bit_r;
`endif

        fifo_wr_en = (state_r == PUSH) && !fifo_full;
        accept_s   = raw_valid && enable && (state_r == COLLECT);

        // Repetition-count test on raw bits; run_len==0 means no previous bit.
        if (accept_s) begin
            prev_bit_s = raw_bit;
            if ((run_len_r == 8'd0) || (raw_bit != prev_bit_r)) begin
                run_len_s = 8'd1;
            end else if (run_len_r < RCT_LIM) begin
                run_len_s = run_len_r + 8'd1;
            end else begin
                run_len_s = run_len_r;
            end
            if (run_len_s == RCT_LIM) begin
                hf_s = 1'b1;
            end else begin
                hf_s = hf_r;
            end
        end else begin
            prev_bit_s = prev_bit_r;
        end

`ifdef TRNG_VN_DEBIAS_EN
        // Von Neumann corrector: 10 -> 1, 01 -> 0, i.e. emit the first bit of
        // an unequal pair; a disable in COLLECT breaks the pairing.
        if (accept_s) begin
            if (!pair_valid_r) begin
                pair_valid_s = 1'b1;
                pair_bit_s   = raw_bit;
            end else begin
                pair_valid_s = 1'b0;
                pack_valid_s = (pair_bit_r != raw_bit);
                pack_bit_s   = pair_bit_r;
            end
        end else if (!enable && (state_r == COLLECT)) begin
            pair_valid_s = 1'b0;
        end else begin
            pair_valid_s = pair_valid_r;
        end
`else
        pack_valid_s = accept_s;
        pack_bit_s   = raw_bit;
`endif

        case (state_r)
            COLLECT: begin
                if (pack_valid_s) begin
                    shift_s = {shift_r[62:0], pack_bit_s};
                    if (cnt_r == 7'd63) begin
                        cnt_s   = 7'd0;
                        din_s   = shift_s;
                        state_s = PUSH;
                    end else begin
                        cnt_s = cnt_r + 7'd1;
                    end
                end else begin
                    shift_s = shift_r;
                end
            end
            PUSH: begin
                // Bits arriving while a word waits are lost; count them.
                if (raw_valid && enable && (drop_r != 16'hFFFF)) begin
                    drop_s = drop_r + 16'd1;
                end else begin
                    drop_s = drop_r;
                end
                if (fifo_wr_en) begin
                    state_s = COLLECT;
                end else begin
                    state_s = PUSH;
                end
            end
            default: begin
                state_s = COLLECT;
            end
        endcase
    end

    assign fifo_din    = din_r;
    assign drop_count  = drop_r;
    assign health_fail = hf_r;

endmodule

// File: tb/tb_trng_word_packer.sv
// Self-checking bench for trng_word_packer: per-cycle comparison against a
// queue-based reference model, a table of whole-word vectors, hand-written
// corner-case sequences and a randomized soak.
module tb_trng_word_packer;

    localparam int RCT = 32;

    logic        clk = 1'b0;
    logic        rst, enable, raw_bit, raw_valid, fifo_full;
    logic        fifo_wr_en;
    logic [63:0] fifo_din;
    logic [15:0] drop_count;
    logic        health_fail;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;

    // reference model state
    bit          m_push;
    bit          m_bits[$];
    bit          m_pair[$];
    logic [63:0] m_din;
    int          m_drop;
    bit          m_hf;
    int          m_run;
    bit          m_prev;

    trng_word_packer #(.RCT_LIMIT(RCT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .raw_bit(raw_bit),
        .raw_valid(raw_valid), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .drop_count(drop_count), .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_emit(input bit b);
        logic [63:0] w;
        m_bits.push_back(b);
        if (m_bits.size() == 64) begin
            w = 64'd0;
            foreach (m_bits[i]) w = w * 64'd2 + 64'(m_bits[i]);
            m_din = w;
            m_bits.delete();
            m_push = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_push = 1'b0; m_bits.delete(); m_pair.delete();
        m_din = 64'd0; m_drop = 0; m_hf = 1'b0; m_run = 0; m_prev = 1'b0;
    endtask

    task automatic model_update(input bit r, input bit en, input bit v, input bit b, input bit f);
        bit first;
        bit was_push;
        if (r) begin
            model_reset();
            return;
        end
        was_push = m_push;
        if (was_push) begin
            if (v && en && m_drop < 65535) m_drop++;
            if (!f) m_push = 1'b0;
        end else if (v && en) begin
            if (m_run == 0 || b != m_prev) m_run = 1;
            else if (m_run < RCT) m_run++;
            m_prev = b;
            if (m_run == RCT) m_hf = 1'b1;
`ifdef TRNG_VN_DEBIAS_EN
            if (m_pair.size() == 0) m_pair.push_back(b);
            else begin
                first = m_pair.pop_front();
                if (first != b) model_emit(first);
            end
`else
            first = b;
            model_emit(first);
`endif
        end else if (!en) begin
            m_pair.delete();
        end
    endtask

    // One clock: drive at negedge, check the combinational strobe, then
    // check registered outputs just after the rising edge.
    task automatic step(input bit r, input bit en, input bit v, input bit b, input bit f);
        @(negedge clk);
        rst = r; enable = en; raw_valid = v; raw_bit = b; fifo_full = f;
        #1;
        check("fifo_wr_en", {63'd0, fifo_wr_en}, {63'd0, m_push && !f});
        if (fifo_wr_en === 1'b1) wr_count++;
        model_update(r, en, v, b, f);
        @(posedge clk);
        #1;
        check("fifo_din", fifo_din, m_din);
        check("drop_count", {48'd0, drop_count}, 64'(m_drop));
        check("health_fail", {63'd0, health_fail}, {63'd0, m_hf});
    endtask

    task automatic feed_word(input logic [63:0] w);
        for (int i = 63; i >= 0; i--) step(1'b0, 1'b1, 1'b1, w[i], 1'b0);
    endtask

    typedef struct {
        logic [63:0] pattern;
        bit          exp_hf;
    } vec_t;

    initial begin
        vec_t        tbl[8];
        logic [63:0] w;
        int          wr0;
        bit          b;
        bit          seen;

        tbl[0] = '{64'hAAAAAAAAAAAAAAAA, 1'b0};
        tbl[1] = '{64'h5555555555555555, 1'b0};
        tbl[2] = '{64'h0123456789ABCDEF, 1'b0};
        tbl[3] = '{64'hFFFF0000FFFF0000, 1'b0};
        tbl[4] = '{64'hFFFFFFFF00000000, 1'b1};
        tbl[5] = '{64'h7FFFFFFE7FFFFFFE, 1'b0};
        tbl[6] = '{64'h00000000FFFFFFFF, 1'b1};
        tbl[7] = '{64'h0000FFFFFFFF0001, 1'b1};

        rst = 1'b1; enable = 1'b0; raw_valid = 1'b0; raw_bit = 1'b0; fifo_full = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        check("reset fifo_din", fifo_din, 64'd0);
        check("reset drop_count", {48'd0, drop_count}, 64'd0);
        check("reset health_fail", {63'd0, health_fail}, 64'd0);
        check("reset fifo_wr_en", {63'd0, fifo_wr_en}, 64'd0);

`ifndef TRNG_VN_DEBIAS_EN
        // table of whole words in raw mode
        for (int t = 0; t < 8; t++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            wr0 = wr_count;
            feed_word(tbl[t].pattern);
            check("tbl no early write", 64'(wr_count - wr0), 64'd0);
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check("tbl write count", 64'(wr_count - wr0), 64'd1);
            check("tbl fifo_din", fifo_din, tbl[t].pattern);
            check("tbl health_fail", {63'd0, health_fail}, {63'd0, tbl[t].exp_hf});
        end

        // reset in the middle of a word
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, i[0], 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        wr0 = wr_count;
        feed_word(64'h5555555555555555);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("midrst writes", 64'(wr_count - wr0), 64'd1);
        check("midrst fifo_din", fifo_din, 64'h5555555555555555);
        check("midrst drop_count", {48'd0, drop_count}, 64'd0);
        check("midrst health_fail", {63'd0, health_fail}, 64'd0);

        // enable gating keeps the partial word
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        w = 64'hC3A5_0F1E_9D7B_2468;
        wr0 = wr_count;
        for (int i = 63; i >= 44; i--) step(1'b0, 1'b1, 1'b1, w[i], 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
        for (int i = 43; i >= 0; i--) step(1'b0, 1'b1, 1'b1, w[i], 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("gate writes", 64'(wr_count - wr0), 64'd1);
        check("gate fifo_din", fifo_din, w);
`else
        // debias: 64 "10" pairs with 10 "00" and 10 "11" pairs mixed in
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wr0 = wr_count;
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (i < 10) begin
                step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
                step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("vn writes", 64'(wr_count - wr0), 64'd1);
        check("vn fifo_din", fifo_din, 64'hFFFFFFFFFFFFFFFF);
`endif

        // back-pressure: word completes while full, 5 bits dropped
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wr0 = wr_count;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'($urandom), 1'b1);
            seen = m_push;
        end
        check("bp word completed", {63'd0, seen}, 64'd1);
        w = fifo_din;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'($urandom), 1'b1);
        check("bp no write while full", 64'(wr_count - wr0), 64'd0);
        check("bp drop_count", {48'd0, drop_count}, 64'd5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bp single write", 64'(wr_count - wr0), 64'd1);
        check("bp fifo_din held", fifo_din, w);
        check("bp drop_count held", {48'd0, drop_count}, 64'd5);

        // health test: 31 ones pass, 32nd trips, stays set, words still flow
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rct 31 ones", {63'd0, health_fail}, 64'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rct 32 ones", {63'd0, health_fail}, 64'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wr0 = wr_count;
        for (int i = 0; i < 400 && wr_count == wr0; i++) step(1'b0, 1'b1, 1'b1, 1'($urandom), 1'b0);
        check("rct word written", {63'd0, wr_count != wr0}, 64'd1);
        check("rct sticky", {63'd0, health_fail}, 64'd1);

        // randomized soak against the model
        b = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (i % 1000 < 500) b = ($urandom_range(0, 39) == 0) ? ~b : b;
            else b = 1'($urandom);
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0), b, ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
